// File: rtl/glb_banked_pkg.sv
`default_nettype none
// ============================================================================
// Module   : glb_banked_pkg
// Purpose  : Shared sizing defaults and request opcode encodings for the
//            banked global buffer.
// Revision : 1.0 - initial release
// ============================================================================
package glb_banked_pkg;

  // Default geometry of the weight global buffer.
  localparam int c_wgt_glb_num_rows  = 64;
  localparam int c_wgt_glb_num_bits  = 8;
  localparam int c_wgt_glb_num_banks = 4;

  // Request opcodes carried on w_req_op.
  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ACC   = 2'b10,
    OP_NOP   = 2'b11
  } glb_op_e;

endpackage
`default_nettype wire

// File: rtl/glb_banked_bank.sv
`default_nettype none
// ============================================================================
// Module   : glb_bank
// Purpose  : One bank of the global buffer: single-address row store with
//            combinational read of the addressed row and synchronous write.
// Revision : 1.0 - initial release
// ============================================================================
module glb_bank #(
  parameter int ROWS   = 16,
  parameter int BITS   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [BITS-1:0]   i_wdata,
  output logic [BITS-1:0]   o_rdata
);

  logic [BITS-1:0] r_mem [ROWS];

  // Commit the addressed row on the rising edge when written.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Pre-update row value, so reads and read-modify-writes see the old data.
  assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/glb_banked.sv
`default_nettype none
// ============================================================================
// Module   : glb_banked
// Purpose  : Banked weight global buffer with read / write / accumulate
//            requests, a parallel zeroing sweep and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module glb_banked
  import glb_banked_pkg::*;
#(
  parameter int WGT_GLB_NUM_ROWS   = c_wgt_glb_num_rows,
  parameter int WGT_GLB_NUM_BITS   = c_wgt_glb_num_bits,
  parameter int WGT_GLB_NUM_BANKS  = c_wgt_glb_num_banks,
  parameter int WGT_GLB_ADDR_WIDTH = $clog2(WGT_GLB_NUM_ROWS)
) (
  input  logic                          w_clock,
  input  logic                          w_reset_n,
  input  logic                          w_req_valid,
  output logic                          w_req_ready,
  input  logic [1:0]                    w_req_op,
  input  logic [WGT_GLB_ADDR_WIDTH-1:0] w_req_address,
  input  logic [WGT_GLB_NUM_BITS-1:0]   w_req_data,
  output logic                          w_rsp_valid,
  output logic [WGT_GLB_NUM_BITS-1:0]   w_rsp_data,
  input  logic                          w_clear,
  output logic                          w_busy,
  output logic                          w_overflow
);

  localparam int ROWS_PER_BANK = WGT_GLB_NUM_ROWS / WGT_GLB_NUM_BANKS;
  localparam int BANK_W        = $clog2(WGT_GLB_NUM_BANKS);
  localparam int ROW_W         = WGT_GLB_ADDR_WIDTH - BANK_W;
  localparam int BITS          = WGT_GLB_NUM_BITS;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ROW_W-1:0]  r_sweep;
  logic              r_rsp_valid;
  logic [BITS-1:0]   r_rsp_data;
  logic              r_overflow;

  logic [BANK_W-1:0] w_bank_idx;
  logic [ROW_W-1:0]  w_row_idx;
  logic              w_accept;
  logic              w_clearing;
  logic              w_sweep_last;
  logic              w_is_read;
  logic              w_is_write;
  logic              w_is_acc;
  logic [BITS-1:0]   w_row_data;
  logic [BITS-1:0]   w_sum;
  logic              w_carry;
  logic [ROW_W-1:0]  w_bank_addr;
  logic [BITS-1:0]   w_bank_wdata;
  logic [BITS-1:0]   w_bank_rdata [WGT_GLB_NUM_BANKS];

  // Low address bits pick the bank, the rest pick the row inside it.
  assign w_bank_idx   = w_req_address[BANK_W-1:0];
  assign w_row_idx    = w_req_address[WGT_GLB_ADDR_WIDTH-1:BANK_W];

  // A pending clear blocks acceptance so the clear wins the cycle.
  assign w_req_ready  = (r_state == ST_IDLE) && !w_clear;
  assign w_accept     = w_req_valid && w_req_ready;
  assign w_clearing   = (r_state == ST_CLEAR);
  assign w_sweep_last = (r_sweep == ROW_W'(ROWS_PER_BANK - 1));

  assign w_is_read    = (w_req_op == OP_READ);
  assign w_is_write   = (w_req_op == OP_WRITE);
  assign w_is_acc     = (w_req_op == OP_ACC);

  assign w_row_data   = w_bank_rdata[w_bank_idx];
  assign {w_carry, w_sum} = {1'b0, w_row_data} + {1'b0, w_req_data};

  // The sweep drives the same row index into every bank at once.
  assign w_bank_addr  = w_clearing ? r_sweep : w_row_idx;
  assign w_bank_wdata = w_clearing ? '0 : (w_is_acc ? w_sum : w_req_data);

  generate
    for (genvar g = 0; g < WGT_GLB_NUM_BANKS; g++) begin : g_bank
      logic w_we;
      assign w_we = w_clearing ||
                    (w_accept && (w_is_write || w_is_acc) &&
                     (w_bank_idx == BANK_W'(g)));

      glb_bank #(
        .ROWS   (ROWS_PER_BANK),
        .BITS   (BITS),
        .ADDR_W (ROW_W)
      ) u_bank (
        .clk     (w_clock),
        .i_we    (w_we),
        .i_addr  (w_bank_addr),
        .i_wdata (w_bank_wdata),
        .o_rdata (w_bank_rdata[g])
      );
    end
  endgenerate

  // Next-state: idle until a clear request, clear until the last sweep row.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_clear)      w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (w_sweep_last) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset lands in CLEAR so the memory is zeroed first.
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) r_state <= ST_CLEAR;
    else            r_state <= w_state_nxt;
  end

  // Sweep row counter: parked at 0 while idle, counts up during a sweep.
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n)      r_sweep <= '0;
    else if (w_clearing) r_sweep <= r_sweep + 1'b1;
    else                 r_sweep <= '0;
  end

  // Read response: one-cycle valid pulse, data held between reads.
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_accept && w_is_read;
      if (w_accept && w_is_read) r_rsp_data <= w_row_data;
    end
  end

  // Sticky accumulate carry flag, cleared when a sweep starts.
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n)                         r_overflow <= 1'b0;
    else if ((r_state == ST_IDLE) && w_clear) r_overflow <= 1'b0;
    else if (w_accept && w_is_acc && w_carry) r_overflow <= 1'b1;
  end

  assign w_rsp_valid = r_rsp_valid;
  assign w_rsp_data  = r_rsp_data;
  assign w_busy      = w_clearing;
  assign w_overflow  = r_overflow;

endmodule
`default_nettype wire
